// File: rtl/fetch_buffer.sv
// Instruction fetch queue: walks a word-aligned PC, captures {pc, instr} from a
// combinational instruction memory, and presents the head with a valid/ready handshake.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [31:0]              imemAddr,
  input  logic [31:0]              imemInstr,
  input  logic                     redirect,
  input  logic [31:0]              redirectPC,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [31:0]              outInstr,
  output logic [31:0]              outPC,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [31:0]               pc;
  logic [AW-1:0]             head, tail;
  logic [DEPTH-1:0][31:0]    pc_q, instr_q;
  logic                      pop, push;

  assign pop      = outValid & outReady;
  // A pop frees a slot this same edge, so a full queue keeps streaming.
  assign push     = ~redirect & ((count != FULL) | pop);
  assign imemAddr = pc;
  assign outValid = (count != '0);
  assign outPC    = pc_q[head];
  assign outInstr = instr_q[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      pc    <= {redirectPC[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc   <= pc + 32'd4;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is only meaningful under count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]    <= pc;
      instr_q[tail] <= imemInstr;
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed + random bench for fetch_buffer; memory returns word index (addr>>2),
// a scoreboard queue holds expected fetch PCs in order.
module tb_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imemAddr, imemInstr, redirectPC, outInstr, outPC;
  logic        redirect = 1'b0, outValid, outReady = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] m_pc;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imemAddr(imemAddr), .imemInstr(imemInstr),
    .redirect(redirect), .redirectPC(redirectPC), .outValid(outValid),
    .outReady(outReady), .outInstr(outInstr), .outPC(outPC), .count(count)
  );

  assign imemInstr = imemAddr >> 2;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check pre-edge state against the model, advance the model, cross the edge.
  task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic pop;
    @(negedge clk);
    outReady = rdy; redirect = rd; redirectPC = rpc;
    #1;
    chk("outValid", 32'(outValid), 32'(q.size() != 0));
    chk("count", 32'(count), 32'(q.size()));
    chk("imemAddr", imemAddr, m_pc);
    if (q.size() != 0) begin
      chk("head_pc", outPC, q[0]);
      chk("head_instr", outInstr, q[0] >> 2);
    end
    pop = (q.size() != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (rd) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (q.size() < DEPTH) begin
      q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_imemAddr", imemAddr, RESET_PC);
    chk("rst_count", 32'(count), 32'd0);
    #1 rst_n = 1'b1;
    q.delete();
    m_pc = RESET_PC;
  endtask

  initial begin
    m_pc = RESET_PC;
    redirectPC = 32'h0;
    #1;
    chk("por_imemAddr", imemAddr, RESET_PC);
    chk("por_outValid", 32'(outValid), 32'd0);
    chk("por_count", 32'(count), 32'd0);
    #6 rst_n = 1'b1;

    // Fill with decoder stalled.
    repeat (6) cyc(1'b0, 1'b0, 32'h0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_imemAddr", imemAddr, 32'h10);
    chk("fill_outPC", outPC, 32'h0);

    // Full streaming: one pop and one push per cycle.
    repeat (8) cyc(1'b1, 1'b0, 32'h0);
    chk("stream_count", 32'(count), 32'd4);
    chk("stream_outPC", outPC, 32'h20);

    // Three entries, then redirect concurrent with a pop.
    cyc(1'b0, 1'b1, 32'h0);
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    chk("three_count", 32'(count), 32'd3);
    cyc(1'b1, 1'b1, 32'h43);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_outValid", 32'(outValid), 32'd0);
    chk("redir_imemAddr", imemAddr, 32'h40);
    cyc(1'b0, 1'b0, 32'h0);
    chk("redir_outValid1", 32'(outValid), 32'd1);
    chk("redir_outPC", outPC, 32'h40);

    // PC wrap at the top of the address space.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_imemAddr", imemAddr, 32'h0);
    chk("wrap_outPC", outPC, 32'hFFFF_FFFC);
    chk("wrap_outInstr", outInstr, 32'h3FFF_FFFF);
    repeat (3) cyc(1'b1, 1'b0, 32'h0);

    // Asynchronous reset pulse between edges with three entries queued.
    cyc(1'b0, 1'b1, 32'h100);
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    chk("pre_rst_count", 32'(count), 32'd3);
    reset_pulse();
    cyc(1'b0, 1'b0, 32'h0);
    chk("post_rst_outPC", outPC, RESET_PC);
    chk("post_rst_imemAddr", imemAddr, RESET_PC + 32'd4);

    // Random backpressure with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      logic rd;
      rd = ($urandom_range(0, 15) == 0);
      cyc(1'(($urandom() & 32'h1) != 0), rd, $urandom());
    end
    repeat (6) cyc(1'b1, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
